// File: rtl/picosoc_pkg.sv
// Shared types and constants for the PicoSoC iomem arbitration slice.
package picosoc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // Master index: 0 = PicoRV32 CPU, 1 = DMA engine.
  typedef logic owner_t;

  localparam owner_t OWNER_CPU = 1'b0;
  localparam owner_t OWNER_DMA = 1'b1;

  // Read data handed back when a peripheral never answers.
  localparam logic [31:0] IOMEM_TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // The request fields that travel from the owner to the peripheral side.
  typedef struct packed {
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } iomem_req_t;

endpackage

// File: rtl/picosoc_iomem_arbiter.sv
// Two-master round-robin arbiter for the PicoSoC iomem bus with a
// per-transfer watchdog that force-completes hung transfers with an error.
module picosoc_iomem_arbiter
  import picosoc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = IOMEM_TIMEOUT_RDATA
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  output logic        m0_err,
  input  logic        m1_valid,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        m1_err,
  output logic        s_valid,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic        timeout_o,
  output logic [7:0]  timeout_count_o
);

  // Timer value seen on the last allowed BUSY cycle.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  arb_state_t  state;
  owner_t      owner;
  owner_t      last_owner;
  logic [15:0] timer;
  logic [7:0]  timeout_count;

  iomem_req_t  req_m0;
  iomem_req_t  req_m1;
  iomem_req_t  req_sel;

  logic        busy;
  logic        own_valid;
  logic        abort;
  logic        done_ok;
  logic        timeout_hit;
  logic        complete;
  logic [31:0] resp_data;

  assign req_m0 = '{wstrb: m0_wstrb, addr: m0_addr, wdata: m0_wdata};
  assign req_m1 = '{wstrb: m1_wstrb, addr: m1_addr, wdata: m1_wdata};

  // Transfer status for the current cycle. A real s_ready always beats the
  // watchdog, and a vanished request (abort) beats both.
  assign busy        = (state == BUSY);
  assign own_valid   = (owner == OWNER_DMA) ? m1_valid : m0_valid;
  assign abort       = busy && !own_valid;
  assign done_ok     = busy && own_valid && s_ready;
  assign timeout_hit = busy && own_valid && !s_ready && (timer == TIMER_LAST);
  assign complete    = done_ok || timeout_hit;

  // Peripheral side: driven only while BUSY so idle/reset outputs are zero
  // and the non-owner's fields never leak through.
  assign req_sel = !busy ? '0 : ((owner == OWNER_DMA) ? req_m1 : req_m0);
  assign s_valid = busy;
  assign s_wstrb = req_sel.wstrb;
  assign s_addr  = req_sel.addr;
  assign s_wdata = req_sel.wdata;

  // Master side: only the owner ever sees ready/err, and rdata is zero
  // whenever its ready is low.
  assign resp_data = done_ok ? s_rdata : TIMEOUT_RDATA;
  assign m0_ready  = complete && (owner == OWNER_CPU);
  assign m1_ready  = complete && (owner == OWNER_DMA);
  assign m0_err    = timeout_hit && (owner == OWNER_CPU);
  assign m1_err    = timeout_hit && (owner == OWNER_DMA);
  assign m0_rdata  = m0_ready ? resp_data : '0;
  assign m1_rdata  = m1_ready ? resp_data : '0;

  assign timeout_o       = timeout_hit;
  assign timeout_count_o = timeout_count;

  // Arbitration FSM, watchdog timer and timeout counter.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; the async reset forces s_valid low immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      owner         <= OWNER_CPU;
      last_owner    <= OWNER_DMA;
      timer         <= '0;
      timeout_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid && m1_valid) begin
            owner <= ~last_owner;
            state <= BUSY;
          end else if (m0_valid) begin
            owner <= OWNER_CPU;
            state <= BUSY;
          end else if (m1_valid) begin
            owner <= OWNER_DMA;
            state <= BUSY;
          end
        end
        BUSY: begin
          timer <= timer + 16'd1;
          if (abort) begin
            // Abandoned request: fairness history stays as it was.
            timer <= '0;
            state <= IDLE;
          end else if (complete) begin
            last_owner <= owner;
            state      <= DONE;
            if (timeout_hit && (timeout_count != 8'hFF)) begin
              timeout_count <= timeout_count + 8'd1;
            end
          end
        end
        DONE: begin
          timer <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_picosoc_iomem_arbiter.sv
// Directed self-checking bench for picosoc_iomem_arbiter (TIMEOUT_CYCLES=8).
module tb_picosoc_iomem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid;
  logic [3:0]  m0_wstrb;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m0_rdata;
  logic        m0_ready;
  logic        m0_err;
  logic        m1_valid;
  logic [3:0]  m1_wstrb;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [31:0] m1_rdata;
  logic        m1_ready;
  logic        m1_err;
  logic        s_valid;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [31:0] s_rdata;
  logic        s_ready;
  logic        timeout_o;
  logic [7:0]  timeout_count_o;

  int checks   = 0;
  int failures = 0;

  picosoc_iomem_arbiter #(
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_RDATA (32'hDEAD_BEEF)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .m0_valid       (m0_valid),
    .m0_wstrb       (m0_wstrb),
    .m0_addr        (m0_addr),
    .m0_wdata       (m0_wdata),
    .m0_rdata       (m0_rdata),
    .m0_ready       (m0_ready),
    .m0_err         (m0_err),
    .m1_valid       (m1_valid),
    .m1_wstrb       (m1_wstrb),
    .m1_addr        (m1_addr),
    .m1_wdata       (m1_wdata),
    .m1_rdata       (m1_rdata),
    .m1_ready       (m1_ready),
    .m1_err         (m1_err),
    .s_valid        (s_valid),
    .s_wstrb        (s_wstrb),
    .s_addr         (s_addr),
    .s_wdata        (s_wdata),
    .s_rdata        (s_rdata),
    .s_ready        (s_ready),
    .timeout_o      (timeout_o),
    .timeout_count_o(timeout_count_o)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 ns later,
  // well clear of the rising edge that the DUT uses.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn   = 1'b0;
    m0_valid = 1'b0; m0_wstrb = '0; m0_addr = '0; m0_wdata = '0;
    m1_valid = 1'b0; m1_wstrb = '0; m1_addr = '0; m1_wdata = '0;
    s_rdata  = '0;   s_ready  = 1'b0;
    tick();
    tick();
    #1;
    checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL reset_s_valid got=%0h exp=0", s_valid); end
    checks++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b%0b exp=00", m0_ready, m1_ready); end
    checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL reset_timeout_o got=%0h exp=0", timeout_o); end
    checks++; if (timeout_count_o !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", timeout_count_o); end
    checks++; if (s_addr !== 32'd0) begin failures++; $display("FAIL reset_s_addr got=%h exp=0", s_addr); end
    tick();
    resetn = 1'b1;
  endtask

  // CPU read, slave answers on the 3rd BUSY cycle with 0x55.
  task automatic test_single_read();
    m0_valid = 1'b1; m0_addr = 32'h0200_0004; m0_wstrb = 4'h0;
    #1;
    checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL rd_idle_s_valid got=%0h exp=0", s_valid); end
    tick(); #1;
    checks++; if (s_valid !== 1'b1) begin failures++; $display("FAIL rd_busy1_s_valid got=%0h exp=1", s_valid); end
    checks++; if (s_addr !== 32'h0200_0004) begin failures++; $display("FAIL rd_s_addr got=%h exp=02000004", s_addr); end
    checks++; if (m0_ready !== 1'b0) begin failures++; $display("FAIL rd_busy1_ready got=%0h exp=0", m0_ready); end
    tick(); #1;
    checks++; if (m0_ready !== 1'b0) begin failures++; $display("FAIL rd_busy2_ready got=%0h exp=0", m0_ready); end
    tick();
    s_ready = 1'b1; s_rdata = 32'h55;
    #1;
    checks++; if (m0_ready !== 1'b1) begin failures++; $display("FAIL rd_ready got=%0h exp=1", m0_ready); end
    checks++; if (m0_rdata !== 32'h55) begin failures++; $display("FAIL rd_rdata got=%h exp=00000055", m0_rdata); end
    checks++; if (m0_err !== 1'b0) begin failures++; $display("FAIL rd_err got=%0h exp=0", m0_err); end
    checks++; if (m1_ready !== 1'b0) begin failures++; $display("FAIL rd_m1_ready got=%0h exp=0", m1_ready); end
    tick();
    m0_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    #1;
    checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL rd_done_s_valid got=%0h exp=0", s_valid); end
    checks++; if (m0_ready !== 1'b0 || m0_rdata !== 32'd0) begin failures++; $display("FAIL rd_done_resp got=%0h/%h exp=0/0", m0_ready, m0_rdata); end
    tick();
  endtask

  // Both masters held from reset with an always-ready slave: m0,m1,m0,m1.
  task automatic test_round_robin();
    logic exp_owner;
    apply_reset();
    m0_valid = 1'b1; m0_addr = 32'h0000_0100; m0_wstrb = 4'h0;
    m1_valid = 1'b1; m1_addr = 32'h0000_0200; m1_wstrb = 4'h0;
    s_ready  = 1'b1; s_rdata = 32'h0000_000A;
    for (int g = 0; g < 4; g++) begin
      exp_owner = g[0];
      #1;
      checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL rr%0d_idle_s_valid got=%0h exp=0", g, s_valid); end
      tick(); #1;
      checks++; if (s_addr !== (exp_owner ? 32'h200 : 32'h100)) begin failures++; $display("FAIL rr%0d_s_addr got=%h exp_owner=%0d", g, s_addr, exp_owner); end
      checks++; if (m0_ready !== !exp_owner || m1_ready !== exp_owner) begin failures++; $display("FAIL rr%0d_ready got=%0b%0b exp_owner=%0d", g, m0_ready, m1_ready, exp_owner); end
      tick(); #1;
      checks++; if (s_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin failures++; $display("FAIL rr%0d_done got=%0b%0b%0b exp=000", g, s_valid, m0_ready, m1_ready); end
      tick();
    end
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    tick();
  endtask

  // Unanswered CPU read: error completion on the 8th BUSY cycle.
  task automatic test_timeout(input logic [7:0] exp_count);
    m0_valid = 1'b1; m0_addr = 32'h0900_0000; m0_wstrb = 4'h0;
    for (int b = 1; b <= 8; b++) begin
      tick(); #1;
      if (b < 8) begin
        checks++; if (m0_ready !== 1'b0 || timeout_o !== 1'b0) begin failures++; $display("FAIL to_early%0d got=%0b%0b exp=00", b, m0_ready, timeout_o); end
      end else begin
        checks++; if (m0_ready !== 1'b1 || m0_err !== 1'b1) begin failures++; $display("FAIL to_ready_err got=%0b%0b exp=11", m0_ready, m0_err); end
        checks++; if (timeout_o !== 1'b1) begin failures++; $display("FAIL to_pulse got=%0h exp=1", timeout_o); end
        checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL to_rdata got=%h exp=deadbeef", m0_rdata); end
        checks++; if (m1_ready !== 1'b0 || m1_err !== 1'b0) begin failures++; $display("FAIL to_m1 got=%0b%0b exp=00", m1_ready, m1_err); end
      end
    end
    tick();
    m0_valid = 1'b0;
    #1;
    checks++; if (timeout_count_o !== exp_count) begin failures++; $display("FAIL to_count got=%0d exp=%0d", timeout_count_o, exp_count); end
    checks++; if (timeout_o !== 1'b0 || s_valid !== 1'b0) begin failures++; $display("FAIL to_done got=%0b%0b exp=00", timeout_o, s_valid); end
    tick();
  endtask

  // s_ready lands on the would-be timeout cycle: plain completion.
  task automatic test_ready_on_timeout(input logic [7:0] exp_count);
    m0_valid = 1'b1; m0_addr = 32'h0900_0004; m0_wstrb = 4'h0;
    for (int b = 1; b <= 8; b++) begin
      tick();
      if (b == 8) begin
        s_ready = 1'b1; s_rdata = 32'h0000_1234;
      end
      #1;
    end
    checks++; if (m0_ready !== 1'b1 || m0_err !== 1'b0) begin failures++; $display("FAIL rt_ready_err got=%0b%0b exp=10", m0_ready, m0_err); end
    checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL rt_pulse got=%0h exp=0", timeout_o); end
    checks++; if (m0_rdata !== 32'h0000_1234) begin failures++; $display("FAIL rt_rdata got=%h exp=00001234", m0_rdata); end
    tick();
    m0_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    #1;
    checks++; if (timeout_count_o !== exp_count) begin failures++; $display("FAIL rt_count got=%0d exp=%0d", timeout_count_o, exp_count); end
    tick();
  endtask

  // CPU transfer, then an aborted DMA write; the following tie goes to m1.
  task automatic test_dma_abort();
    m0_valid = 1'b1; m0_addr = 32'h0200_0008; s_ready = 1'b1; s_rdata = 32'h77;
    tick(); #1;
    checks++; if (m0_ready !== 1'b1) begin failures++; $display("FAIL ab_pre_ready got=%0h exp=1", m0_ready); end
    tick();
    m0_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    tick();
    m1_valid = 1'b1; m1_wstrb = 4'hF; m1_addr = 32'h0300_0010; m1_wdata = 32'hCAFE_F00D;
    tick(); #1;
    checks++; if (s_valid !== 1'b1 || s_wstrb !== 4'hF) begin failures++; $display("FAIL ab_busy1 got=%0b/%h exp=1/f", s_valid, s_wstrb); end
    checks++; if (s_addr !== 32'h0300_0010 || s_wdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL ab_mux got=%h/%h exp=03000010/cafef00d", s_addr, s_wdata); end
    tick(); #1;
    checks++; if (m1_ready !== 1'b0) begin failures++; $display("FAIL ab_busy2_ready got=%0h exp=0", m1_ready); end
    tick();
    m1_valid = 1'b0;
    #1;
    checks++; if (m1_ready !== 1'b0 || m1_rdata !== 32'd0) begin failures++; $display("FAIL ab_drop_ready got=%0h/%h exp=0/0", m1_ready, m1_rdata); end
    tick(); #1;
    checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL ab_s_valid_fall got=%0h exp=0", s_valid); end
    m0_valid = 1'b1; m0_addr = 32'h0000_0100;
    m1_valid = 1'b1; m1_addr = 32'h0000_0200; m1_wstrb = 4'h0;
    s_ready  = 1'b1; s_rdata = 32'h99;
    tick(); #1;
    checks++; if (m1_ready !== 1'b1 || m0_ready !== 1'b0) begin failures++; $display("FAIL ab_tie got=%0b%0b exp=m1", m0_ready, m1_ready); end
    checks++; if (m1_rdata !== 32'h99) begin failures++; $display("FAIL ab_tie_rdata got=%h exp=00000099", m1_rdata); end
    tick();
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    tick();
  endtask

  // Async reset in the middle of a transfer, then the first tie goes to m0.
  task automatic test_reset_mid_busy();
    m0_valid = 1'b1; m0_addr = 32'h0400_0000;
    tick(); #1;
    checks++; if (s_valid !== 1'b1) begin failures++; $display("FAIL rm_busy got=%0h exp=1", s_valid); end
    tick();
    resetn = 1'b0; s_ready = 1'b1; s_rdata = 32'h11;
    #1;
    checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL rm_s_valid got=%0h exp=0", s_valid); end
    checks++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin failures++; $display("FAIL rm_ready got=%0b%0b exp=00", m0_ready, m1_ready); end
    checks++; if (timeout_count_o !== 8'd0) begin failures++; $display("FAIL rm_count got=%0d exp=0", timeout_count_o); end
    m0_valid = 1'b0; s_ready = 1'b0;
    tick();
    resetn = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h0000_0100;
    m1_valid = 1'b1; m1_addr = 32'h0000_0200;
    s_ready  = 1'b1;
    tick(); #1;
    checks++; if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin failures++; $display("FAIL rm_tie got=%0b%0b exp=m0", m0_ready, m1_ready); end
    tick();
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    tick();
  endtask

  // 256 back-to-back timeouts; the counter must stop at 255.
  task automatic test_count_saturation();
    apply_reset();
    for (int n = 1; n <= 256; n++) begin
      m0_valid = 1'b1; m0_addr = 32'h0900_0100;
      repeat (8) tick();
      tick();
      m0_valid = 1'b0;
      #1;
      checks++; if (timeout_count_o !== ((n > 255) ? 8'd255 : 8'(n))) begin failures++; $display("FAIL sat%0d got=%0d exp=%0d", n, timeout_count_o, (n > 255) ? 255 : n); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_timeout(8'd1);
    test_ready_on_timeout(8'd1);
    test_dma_abort();
    test_reset_mid_busy();
    test_count_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim_time=%0t limit=500000", $time);
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/picosoc_iomem_arbiter.md
Name: picosoc_iomem_arbiter

Overview:
- Two-master arbiter for the PicoSoC iomem peripheral bus.
- Master 0 is the PicoRV32 CPU; master 1 is the planned SD-card/SDRAM DMA engine.
- Sits between the masters and the existing address decode/ready/rdata mux, presenting a single iomem master to it.
- Adds round-robin fairness and a bus-timeout watchdog, so an unmapped or hung peripheral cannot stall the SoC forever.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles a granted transfer may wait for s_ready before forced error completion; legal range 2..65535.
- TIMEOUT_RDATA, 32'hDEAD_BEEF: read data returned on a timed-out transfer.

Ports:
- clk  in  1  logic clock (a2bus_if.clk_logic domain).
- resetn  in  1  asynchronous, active-low reset.
- m0_valid  in  1  CPU request; held stable until m0_ready.
- m0_wstrb  in  4  CPU byte write strobes; 0 = read.
- m0_addr  in  32  CPU address.
- m0_wdata  in  32  CPU write data.
- m0_rdata  out  32  CPU read data; valid when m0_ready=1.
- m0_ready  out  1  CPU completion pulse.
- m0_err  out  1  qualifies m0_ready: transfer timed out.
- m1_valid  in  1  DMA request.
- m1_wstrb  in  4  DMA byte write strobes.
- m1_addr  in  32  DMA address.
- m1_wdata  in  32  DMA write data.
- m1_rdata  out  32  DMA read data.
- m1_ready  out  1  DMA completion pulse.
- m1_err  out  1  qualifies m1_ready: transfer timed out.
- s_valid  out  1  request to the peripheral decode.
- s_wstrb  out  4  muxed byte strobes.
- s_addr  out  32  muxed address.
- s_wdata  out  32  muxed write data.
- s_rdata  in  32  data from the peripheral mux.
- s_ready  in  1  completion from the peripheral mux.
- timeout_o  out  1  one-cycle pulse per timeout.
- timeout_count_o  out  8  saturating count of timeouts.

Behaviour:
- Reset: resetn is asynchronous, active-low, one clock (clk). On reset, all outputs are 0, state=IDLE, last_owner=1, timer=0, timeout_count=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Nothing requested: stay in IDLE.
  - Exactly one mx_valid: owner<=x, go to BUSY next edge.
  - Both valid: owner <= ~last_owner (round-robin). After reset the CPU wins the first tie.
  - Arbitration latency is 1 cycle: s_valid first rises the cycle after the request is seen.
- BUSY:
  - s_valid=1; s_addr/s_wstrb/s_wdata combinationally from the owner; the non-owner's inputs are ignored.
  - s_ready=1: owner's mx_ready=1 and mx_rdata=s_rdata in the same cycle (combinational). Then last_owner<=owner and go to DONE.
  - Owner drops mx_valid before s_ready (abort, DMA only): go to IDLE without a ready pulse; last_owner is not updated.
  - Timer increments each BUSY cycle. If timer==TIMEOUT_CYCLES-1 and s_ready=0: owner gets mx_ready=1, mx_err=1, mx_rdata=TIMEOUT_RDATA; timeout_o=1; timeout_count_o+1 (saturating at 255); go to DONE.
  - s_ready and the timeout in the same cycle: treat as a normal completion (no err, no count).
- DONE:
  - s_valid=0 for exactly one cycle, so every peripheral observes valid low between transfers. Peripherals must abandon a transfer when valid falls.
  - Timer<=0, then go to IDLE.
  - Minimum back-to-back spacing is 3 cycles per transfer.
- Non-owner mx_ready/mx_err are always 0; mx_rdata is 0 whenever mx_ready=0.
- A reset assertion mid-BUSY drops s_valid immediately (asynchronously), with no ready pulse to either master.

Decomposition:
- Shared package picosoc_pkg:
  - enum arb_state_t {IDLE, BUSY, DONE}.
  - typedef logic owner_t.
  - Constant IOMEM_TIMEOUT_RDATA.
  - Typedef iomem_req_t struct {wstrb, addr, wdata} for the muxing.
- No sub-module: the timer and FSM fit in a single module.

Test Plan:
- Reset, then CPU read of 0x0200_0004 with a slave ready after 3 cycles and s_rdata=0x55 → s_valid high 1 cycle after m0_valid; m0_ready one pulse with m0_rdata=0x55; m0_err=0; s_valid low for 1 cycle afterwards.
- m0_valid and m1_valid asserted together from reset, both held → grants go m0, m1, m0, m1; each mx_ready pulses once per grant; s_addr matches the owner throughout.
- TIMEOUT_CYCLES=8, CPU read of 0x0900_0000 with s_ready never asserted → m0_ready, m0_err and timeout_o high on the 8th BUSY cycle; m0_rdata=0xDEADBEEF; timeout_count_o=1.
- s_ready asserted on exactly the timeout cycle → normal completion, m0_err=0, timeout_count_o unchanged.
- DMA write with wstrb=4'hF, m1_valid dropped after 2 BUSY cycles → s_valid falls the next cycle; no m1_ready; the next tie is still granted to m1.
- resetn pulsed low mid-BUSY → s_valid and all ready outputs 0 asynchronously; timeout_count_o=0; the next tie is granted to m0.
